// File: rtl/tl_pkg.sv
// TileLink-UL channel payloads and opcode constants shared by the
// memory adapter and anything that talks to it.
package tl_pkg;

  localparam int TL_ADDR_W   = 64;
  localparam int TL_DATA_W   = 64;
  localparam int TL_MASK_W   = TL_DATA_W / 8;
  localparam int TL_SIZE_W   = 4;
  localparam int TL_SOURCE_W = 8;
  localparam int TL_SINK_W   = 8;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] GET              = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] ACCESS_ACK       = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
    logic [TL_ADDR_W-1:0]   address;
    logic [TL_MASK_W-1:0]   mask;
    logic [TL_DATA_W-1:0]   data;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
    logic [TL_SINK_W-1:0]   sink;
    logic                   denied;
    logic                   corrupt;
    logic [TL_DATA_W-1:0]   data;
  } D_chan_bits_t;

endpackage

// File: rtl/tl_mem_adapter.sv
// TileLink-UL slave that turns Get / PutFullData / PutPartialData bursts
// into beat-by-beat accesses on a single-port SRAM with 1-cycle read latency.
// One transaction in flight; illegal requests are answered with denied=1
// without touching memory. ADDR_WTH/DATA_WTH must match the tl_pkg widths.
module tl_mem_adapter
  import tl_pkg::*;
#(
  parameter int ADDR_WTH = 64,
  parameter int DATA_WTH = 64,
  parameter int MAX_SIZE = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  A_valid_i,
  output logic                  A_ready_o,
  input  tl_pkg::A_chan_bits_t  A_bits_i,
  output logic                  D_valid_o,
  input  logic                  D_ready_i,
  output tl_pkg::D_chan_bits_t  D_bits_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WTH-1:0]   mem_addr_o,
  output logic [DATA_WTH-1:0]   mem_wdata_o,
  output logic [DATA_WTH/8-1:0] mem_be_o,
  input  logic [DATA_WTH-1:0]   mem_rdata_i
);

  localparam int BYTES   = DATA_WTH / 8;
  localparam int BEAT_LG = $clog2(BYTES);
  // wide enough for the beat count of the largest encodable size
  localparam int CNT_W   = 17;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_RSP, WR_BEAT, WR_RSP, ERR_DRAIN, ERR_RSP
  } state_e;

  // beats in a burst: one per memory word, at least one
  function automatic logic [CNT_W-1:0] beat_total(input logic [TL_SIZE_W-1:0] size);
    if (int'(size) <= BEAT_LG) return CNT_W'(1);
    return CNT_W'(1) << (int'(size) - BEAT_LG);
  endfunction

  // low address bits inside a 2^size block
  function automatic logic [ADDR_WTH-1:0] blk_mask(input logic [TL_SIZE_W-1:0] size);
    return ~({ADDR_WTH{1'b1}} << size);
  endfunction

  // next beat address, wrapping inside the 2^size block
  function automatic logic [ADDR_WTH-1:0] next_addr(input logic [ADDR_WTH-1:0] addr,
                                                    input logic [TL_SIZE_W-1:0] size);
    logic [ADDR_WTH-1:0] m;
    m = blk_mask(size);
    return (addr & ~m) | ((addr + ADDR_WTH'(BYTES)) & m);
  endfunction

  state_e                 state_q,  state_d;
  logic [2:0]             opcode_q, opcode_d;
  logic [TL_SIZE_W-1:0]   size_q,   size_d;
  logic [TL_SOURCE_W-1:0] source_q, source_d;
  logic [ADDR_WTH-1:0]    addr_q,   addr_d;
  logic [CNT_W-1:0]       beats_q,  beats_d;
  logic [DATA_WTH-1:0]    rdata_q,  rdata_d;

  logic                   mem_req_c, mem_we_c;
  logic [ADDR_WTH-1:0]    mem_addr_c;
  logic [DATA_WTH-1:0]    mem_wdata_c;
  logic [BYTES-1:0]       mem_be_c;
  logic                   d_valid_c;
  D_chan_bits_t           d_bits_c;

  logic [ADDR_WTH-1:0]    a_addr, a_beat_addr;
  logic [CNT_W-1:0]       a_total;
  logic                   a_is_get, a_is_put, a_legal, a_hs;

  assign a_addr      = A_bits_i.address[ADDR_WTH-1:0];
  assign a_beat_addr = a_addr & ~ADDR_WTH'(BYTES - 1);
  assign a_total     = beat_total(A_bits_i.size);
  assign a_is_get    = (A_bits_i.opcode == GET);
  assign a_is_put    = (A_bits_i.opcode == PUT_FULL_DATA) ||
                       (A_bits_i.opcode == PUT_PARTIAL_DATA);
  assign a_legal     = (a_is_get || a_is_put) &&
                       (int'(A_bits_i.size) <= MAX_SIZE) &&
                       ((a_addr & blk_mask(A_bits_i.size)) == '0);

  // A beats are only taken when idle or while collecting/draining write data
  assign A_ready_o = rst_i && ((state_q == IDLE) || (state_q == WR_BEAT) ||
                               (state_q == ERR_DRAIN));
  assign a_hs      = A_valid_i && A_ready_o;

  // next-state, request capture and SRAM strobe decode
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    size_d      = size_q;
    source_d    = source_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    rdata_d     = rdata_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_be_c    = '0;
    case (state_q)
      IDLE: begin
        if (a_hs) begin
          opcode_d = A_bits_i.opcode;
          size_d   = A_bits_i.size;
          source_d = A_bits_i.source;
          if (a_legal && a_is_get) begin
            addr_d  = a_beat_addr;
            beats_d = a_total;
            state_d = RD_REQ;
          end else if (a_legal) begin
            // first write beat goes straight to memory in the accepting cycle
            mem_req_c   = 1'b1;
            mem_we_c    = 1'b1;
            mem_addr_c  = a_beat_addr;
            mem_wdata_c = A_bits_i.data[DATA_WTH-1:0];
            mem_be_c    = A_bits_i.mask[BYTES-1:0];
            addr_d      = next_addr(a_beat_addr, A_bits_i.size);
            beats_d     = a_total - CNT_W'(1);
            state_d     = (a_total == CNT_W'(1)) ? WR_RSP : WR_BEAT;
          end else if (a_is_put) begin
            beats_d = a_total - CNT_W'(1);
            state_d = (a_total == CNT_W'(1)) ? ERR_RSP : ERR_DRAIN;
          end else begin
            beats_d = '0;
            state_d = ERR_RSP;
          end
        end
      end
      RD_REQ: begin
        mem_req_c  = 1'b1;
        mem_addr_c = addr_q;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d = mem_rdata_i;
        state_d = RD_RSP;
      end
      RD_RSP: begin
        if (D_ready_i) begin
          if (beats_q == CNT_W'(1)) begin
            beats_d = '0;
            state_d = IDLE;
          end else begin
            beats_d = beats_q - CNT_W'(1);
            addr_d  = next_addr(addr_q, size_q);
            state_d = RD_REQ;
          end
        end
      end
      WR_BEAT: begin
        if (a_hs) begin
          mem_req_c   = 1'b1;
          mem_we_c    = 1'b1;
          mem_addr_c  = addr_q;
          mem_wdata_c = A_bits_i.data[DATA_WTH-1:0];
          mem_be_c    = A_bits_i.mask[BYTES-1:0];
          addr_d      = next_addr(addr_q, size_q);
          beats_d     = beats_q - CNT_W'(1);
          if (beats_q == CNT_W'(1)) state_d = WR_RSP;
        end
      end
      ERR_DRAIN: begin
        if (a_hs) begin
          beats_d = beats_q - CNT_W'(1);
          if (beats_q == CNT_W'(1)) state_d = ERR_RSP;
        end
      end
      WR_RSP, ERR_RSP: begin
        if (D_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // D-channel payload, derived only from registered state so it holds under backpressure
  always_comb begin
    d_valid_c = 1'b0;
    d_bits_c  = '0;
    case (state_q)
      RD_RSP: begin
        d_valid_c       = 1'b1;
        d_bits_c.opcode = ACCESS_ACK_DATA;
        d_bits_c.data   = rdata_q;
      end
      WR_RSP: begin
        d_valid_c       = 1'b1;
        d_bits_c.opcode = ACCESS_ACK;
      end
      ERR_RSP: begin
        d_valid_c        = 1'b1;
        d_bits_c.opcode  = (opcode_q == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
        d_bits_c.denied  = 1'b1;
        d_bits_c.corrupt = (opcode_q == GET);
      end
      default: d_valid_c = 1'b0;
    endcase
    if (d_valid_c) begin
      d_bits_c.size   = size_q;
      d_bits_c.source = source_q;
    end
  end

  // all outputs are held quiet while reset is asserted
  assign D_valid_o   = rst_i && d_valid_c;
  assign D_bits_o    = rst_i ? d_bits_c : '0;
  assign mem_req_o   = rst_i && mem_req_c;
  assign mem_we_o    = rst_i && mem_we_c;
  assign mem_addr_o  = rst_i ? mem_addr_c  : '0;
  assign mem_wdata_o = rst_i ? mem_wdata_c : '0;
  assign mem_be_o    = rst_i ? mem_be_c    : '0;

  // state and request registers; reset abandons any in-flight transaction
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      size_q   <= '0;
      source_q <= '0;
      addr_q   <= '0;
      beats_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      size_q   <= size_d;
      source_q <= source_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
